// File: rtl/seg_pkg.sv
// Shared seven-segment constants and the display history entry type.
package seg_pkg;

  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1100111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b1000000;

  typedef struct packed {
    logic             ovf;
    logic [SEG_W-1:0] seg;
  } hist_entry_t;

endpackage

// File: rtl/seg_scan_prescaler.sv
// Free-running divide-by-DIV counter; scan_tick_c is high on the terminal count.
module seg_scan_prescaler #(
  parameter int unsigned DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic scan_tick_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] r_cnt;

  assign scan_tick_c = (r_cnt == CNT_W'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (scan_tick_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg_display_scan.sv
// Multiplexed seven-segment display of the last NUM_DIGITS decoder results.
// Optional macro SEG_SCAN_GHOST_BLANK_EN inserts a dead cycle at each digit change.
module seg_display_scan
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic                  ovf_in,
  input  logic                  load,
  input  logic                  clr,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [NUM_DIGITS-1:0] an_out
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  hist_entry_t           r_hist [NUM_DIGITS];
  logic [IDX_W-1:0]      r_idx;
  logic [FRM_W-1:0]      r_frame;
  logic                  r_blink;

  logic                  w_scan_tick;
  logic                  w_idx_wrap;
  logic                  w_frame_wrap;
  hist_entry_t           w_sel;
  logic [SEG_W-1:0]      w_seg_nxt;
  logic                  w_dp_nxt;
  logic [NUM_DIGITS-1:0] w_an_nxt;

  seg_scan_prescaler #(
    .DIV (SCAN_DIV)
  ) u_prescaler (
    .clk         (clk),
    .rst         (rst),
    .scan_tick_c (w_scan_tick)
  );

  // History shift register; clear takes priority over a simultaneous load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_hist[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_hist[i] <= '0;
    end else if (load) begin
      r_hist[0] <= {ovf_in, seg_in};
      for (int i = 1; i < NUM_DIGITS; i++) r_hist[i] <= r_hist[i-1];
    end
  end

  assign w_idx_wrap   = (r_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_frame_wrap = (r_frame == FRM_W'(BLINK_FRAMES - 1));

  // Digit index, frame counter and blink phase advance only on scan ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_frame <= '0;
      r_blink <= 1'b0;
    end else if (w_scan_tick) begin
      if (w_idx_wrap) begin
        r_idx <= '0;
        if (w_frame_wrap) begin
          r_frame <= '0;
          r_blink <= ~r_blink;
        end else begin
          r_frame <= r_frame + FRM_W'(1);
        end
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

`ifdef SEG_SCAN_GHOST_BLANK_EN
  logic r_tick_d;

  // Marks the first cycle after the index moved, which is driven dark.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_d <= 1'b0;
    end else begin
      r_tick_d <= w_scan_tick;
    end
  end
`endif

  always_comb begin
    w_sel    = '0;
    w_an_nxt = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_sel       = r_hist[i];
        w_an_nxt[i] = 1'b1;
      end
    end
    // Overflowed entries: blinking dash, decimal point held steady.
    w_dp_nxt  = w_sel.ovf;
    w_seg_nxt = w_sel.ovf ? (r_blink ? SEG_BLANK : SEG_DASH) : w_sel.seg;
`ifdef SEG_SCAN_GHOST_BLANK_EN
    if (r_tick_d) begin
      w_an_nxt  = '0;
      w_seg_nxt = SEG_BLANK;
      w_dp_nxt  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_out <= SEG_BLANK;
      dp_out  <= 1'b0;
      an_out  <= NUM_DIGITS'(1);
    end else begin
      seg_out <= w_seg_nxt;
      dp_out  <= w_dp_nxt;
      an_out  <= w_an_nxt;
    end
  end

endmodule

// File: tb/tb_seg_display_scan.sv
// Randomized and directed bench for seg_display_scan against a cycle-count based model.
module tb_seg_display_scan;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int BF = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [6:0]   seg_in;
  logic         ovf_in;
  logic         load;
  logic         clr;
  logic [6:0]   seg_out;
  logic         dp_out;
  logic [N-1:0] an_out;

  int total = 0;
  int bad   = 0;

  // Model: history as a list (newest first) and edges elapsed since reset release.
  logic [7:0]   m_hist [$];
  int           m_t;
  logic [6:0]   exp_seg;
  logic         exp_dp;
  logic [N-1:0] exp_an;

  always #5 clk = ~clk;

  seg_display_scan #(
    .NUM_DIGITS   (N),
    .SCAN_DIV     (D),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .seg_in  (seg_in),
    .ovf_in  (ovf_in),
    .load    (load),
    .clr     (clr),
    .seg_out (seg_out),
    .dp_out  (dp_out),
    .an_out  (an_out)
  );

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < N; i++) m_hist.push_back(8'h00);
    m_t = 0;
  endtask

  // Drives one cycle of inputs, advances one clock and predicts the outputs after that edge.
  task automatic tick(input logic ld, input logic cl, input logic [6:0] s, input logic o);
    int         idx;
    int         ph;
    logic [7:0] e;
    load   = ld;
    clr    = cl;
    seg_in = s;
    ovf_in = o;
    idx = (m_t / D) % N;
    ph  = (m_t / (D * N * BF)) % 2;
    e   = m_hist[idx];
    exp_an      = '0;
    exp_an[idx] = 1'b1;
    exp_dp      = e[7];
    exp_seg     = e[7] ? ((ph == 1) ? 7'b0000000 : 7'b1000000) : e[6:0];
`ifdef SEG_SCAN_GHOST_BLANK_EN
    if ((m_t % D == 0) && (m_t >= D)) begin
      exp_an  = '0;
      exp_seg = 7'b0;
      exp_dp  = 1'b0;
    end
`endif
    @(posedge clk);
    #1;
    if (cl) begin
      for (int i = 0; i < N; i++) m_hist[i] = 8'h00;
    end else if (ld) begin
      m_hist.push_front({o, s});
      void'(m_hist.pop_back());
    end
    m_t++;
    load = 1'b0;
    clr  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 0; clr = 0; seg_in = 0; ovf_in = 0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (seg_out !== 7'b0 || dp_out !== 1'b0 || an_out !== 4'b0001) begin
      bad++;
      $display("FAIL reset_hold seg=%b dp=%b an=%b need 0000000/0/0001", seg_out, dp_out, an_out);
    end
    rst = 1'b0;
    model_reset();
    #1;
    total++;
    if (seg_out !== 7'b0 || dp_out !== 1'b0 || an_out !== 4'b0001) begin
      bad++;
      $display("FAIL reset_release seg=%b dp=%b an=%b need 0000000/0/0001", seg_out, dp_out, an_out);
    end
  endtask

  task automatic test_idle_scan();
    for (int c = 0; c < 40; c++) begin
      tick(0, 0, 7'h00, 0);
      total++;
      if (seg_out !== exp_seg || dp_out !== exp_dp || an_out !== exp_an) begin
        bad++;
        $display("FAIL idle t=%0d seg=%b/%b dp=%b/%b an=%b/%b", m_t, seg_out, exp_seg, dp_out, exp_dp, an_out, exp_an);
      end
    end
  endtask

  task automatic test_single_load();
    tick(1, 0, 7'b1011011, 0);
    for (int c = 0; c < 2 * N * D; c++) begin
      tick(0, 0, 7'h00, 0);
      total++;
      if (seg_out !== exp_seg || dp_out !== exp_dp || an_out !== exp_an) begin
        bad++;
        $display("FAIL single_load t=%0d seg=%b/%b dp=%b/%b an=%b/%b", m_t, seg_out, exp_seg, dp_out, exp_dp, an_out, exp_an);
      end
    end
  endtask

  task automatic test_shift();
    logic [6:0] digs [5];
    logic [6:0] want;
    digs[0] = 7'b0000110; digs[1] = 7'b1001111; digs[2] = 7'b1101101;
    digs[3] = 7'b1100111; digs[4] = 7'b0111111;
    for (int k = 0; k < 5; k++) begin
      tick(1, 0, digs[k], 0);
      for (int c = 0; c < N * D + 3; c++) begin
        tick(0, 0, 7'h00, 0);
        total++;
        if (seg_out !== exp_seg || dp_out !== exp_dp || an_out !== exp_an) begin
          bad++;
          $display("FAIL shift_model k=%0d t=%0d seg=%b/%b dp=%b/%b an=%b/%b", k, m_t, seg_out, exp_seg, dp_out, exp_dp, an_out, exp_an);
        end
        // Fixed expectations once 1,3,5,9 (and later 0) have been loaded.
        if (k >= 3) begin
          case (an_out)
            4'b0001: want = (k == 3) ? 7'b1100111 : 7'b0111111;
            4'b0010: want = (k == 3) ? 7'b1101101 : 7'b1100111;
            4'b0100: want = (k == 3) ? 7'b1001111 : 7'b1101101;
            default: want = (k == 3) ? 7'b0000110 : 7'b1001111;
          endcase
          if (an_out != 4'b0000) begin
            total++;
            if (seg_out !== want) begin
              bad++;
              $display("FAIL shift_digit k=%0d an=%b seg=%b need %b", k, an_out, seg_out, want);
            end
          end
        end
      end
    end
  endtask

  task automatic test_overflow_blink();
    tick(1, 0, 7'h00, 1);
    for (int c = 0; c < 5 * N * D * BF; c++) begin
      tick(0, 0, 7'h00, 0);
      total++;
      if (seg_out !== exp_seg || dp_out !== exp_dp || an_out !== exp_an) begin
        bad++;
        $display("FAIL ovf_blink t=%0d seg=%b/%b dp=%b/%b an=%b/%b", m_t, seg_out, exp_seg, dp_out, exp_dp, an_out, exp_an);
      end
    end
  endtask

  task automatic test_clr_load();
    tick(1, 1, 7'b1111111, 0);
    for (int c = 0; c < N * D + 2; c++) begin
      tick(0, 0, 7'h00, 0);
      total++;
      if (seg_out !== 7'b0 || dp_out !== 1'b0 || an_out !== exp_an) begin
        bad++;
        $display("FAIL clr_load t=%0d seg=%b dp=%b an=%b need 0000000/0/%b", m_t, seg_out, dp_out, an_out, exp_an);
      end
    end
  endtask

  task automatic test_reset_midscan();
    tick(1, 0, 7'b1100110, 0);
    while (((m_t / D) % N) != 2 || (m_t % D) != 1) tick(0, 0, 7'h00, 0);
    tick(0, 0, 7'h00, 0);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (seg_out !== 7'b0 || dp_out !== 1'b0 || an_out !== 4'b0001) begin
      bad++;
      $display("FAIL rst_midscan seg=%b dp=%b an=%b need 0000000/0/0001", seg_out, dp_out, an_out);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 2 * N * D; c++) begin
      tick(0, 0, 7'h00, 0);
      total++;
      if (seg_out !== exp_seg || dp_out !== exp_dp || an_out !== exp_an) begin
        bad++;
        $display("FAIL rst_restart t=%0d seg=%b/%b dp=%b/%b an=%b/%b", m_t, seg_out, exp_seg, dp_out, exp_dp, an_out, exp_an);
      end
    end
  endtask

  task automatic test_random();
    logic ld;
    logic cl;
    for (int c = 0; c < 600; c++) begin
      ld = ($urandom_range(0, 3) == 0);
      cl = ($urandom_range(0, 29) == 0);
      tick(ld, cl, 7'($urandom), 1'($urandom_range(0, 2) == 0));
      total++;
      if (seg_out !== exp_seg || dp_out !== exp_dp || an_out !== exp_an) begin
        bad++;
        $display("FAIL random t=%0d seg=%b/%b dp=%b/%b an=%b/%b", m_t, seg_out, exp_seg, dp_out, exp_dp, an_out, exp_an);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_single_load();
    test_shift();
    test_overflow_blink();
    test_clr_load();
    test_reset_midscan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
